axilite_req_scheduler: RTL and testbench

AXILITE_REQ_SCHEDULER -- requirements
Module: axilite_req_scheduler

---
 rtl/axilite_noc_pkg.sv | 41 ++++
 rtl/axilite_req_scheduler_arb.sv | 27 ++
 rtl/axilite_req_scheduler.sv | 154 +++++++++++++++
 tb/tb_axilite_req_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axilite_noc_pkg.sv
// Shared types for the AXI-lite to NoC request path: message codes,
// the response-side transaction-info record and the scheduler FSM states.
package axilite_noc_pkg;

  localparam logic [1:0] MSG_TYPE_LOAD  = 2'd1;
  localparam logic [1:0] MSG_TYPE_STORE = 2'd2;

  typedef struct packed {
    logic       is_store;
    logic       is_load;
    logic       rsvd;
    logic       addr_b3;
    logic [1:0] msg_type;
  } txn_info_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_e;

  function automatic txn_info_t load_info(input logic addr_b3);
    txn_info_t t;
    t.is_store = 1'b0;
    t.is_load  = 1'b1;
    t.rsvd     = 1'b0;
    t.addr_b3  = addr_b3;
    t.msg_type = MSG_TYPE_LOAD;
    return t;
  endfunction

  function automatic txn_info_t store_info();
    txn_info_t t;
    t.is_store = 1'b1;
    t.is_load  = 1'b0;
    t.rsvd     = 1'b0;
    t.addr_b3  = 1'b0;
    t.msg_type = MSG_TYPE_STORE;
    return t;
  endfunction

endpackage

// File: rtl/axilite_req_scheduler_arb.sv
// Two-way round-robin arbiter between the read and write slots; the
// registered last grant starts on write so the first contention goes to read.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_rd,
  input  logic req_wr,
  input  logic advance,
  output logic gnt_rd,
  output logic gnt_wr
);

  logic last_wr;

  always_comb begin
    gnt_rd = req_rd && (!req_wr || last_wr);
    gnt_wr = req_wr && (!req_rd || !last_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_wr <= 1'b1;
    else if (advance && (gnt_rd || gnt_wr))
      last_wr <= gnt_wr;
  end

endmodule

// File: rtl/axilite_req_scheduler.sv
// Captures AXI-lite AR / AW / W into single-entry slots and issues them one
// at a time to the NoC request encoder, bounded by a retire-credit counter.
module axilite_req_scheduler
  import axilite_noc_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDR_WIDTH-1:0]                  s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]                  s_axi_awaddr,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                  s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]                s_axi_wstrb,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic                                   req_valid,
  input  logic                                   req_ready,
  output logic                                   req_is_store,
  output logic [ADDR_WIDTH-1:0]                  req_addr,
  output logic [DATA_WIDTH-1:0]                  req_wdata,
  output logic [DATA_WIDTH/8-1:0]                req_wstrb,
  output logic [5:0]                             txn_info_wr_data,
  output logic                                   txn_info_wr,
  input  logic                                   rsp_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_underflow
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  sched_state_e          state;
  txn_info_t             info_q;
  logic                  rd_full, aw_full, w_full;
  logic [ADDR_WIDTH-1:0] rd_addr, aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  hs, can_grant, gnt_rd, gnt_wr;

  assign s_axi_arready    = !rd_full;
  assign s_axi_awready    = !aw_full;
  assign s_axi_wready     = !w_full;
  assign hs               = req_valid && req_ready;
  assign txn_info_wr      = hs;
  assign txn_info_wr_data = info_q;
  assign can_grant        = (state == ST_IDLE) && (rd_full || (aw_full && w_full))
                            && (outstanding < MAX_CNT);

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_rd  (rd_full),
    .req_wr  (aw_full && w_full),
    .advance (can_grant),
    .gnt_rd  (gnt_rd),
    .gnt_wr  (gnt_wr)
  );

  // Slots clear only on handshake; ready is low while full, so load and clear never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_full <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      rd_addr <= '0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (hs && !req_is_store)
        rd_full <= 1'b0;
      else if (s_axi_arvalid && s_axi_arready) begin
        rd_full <= 1'b1;
        rd_addr <= s_axi_araddr;
      end
      if (hs && req_is_store)
        aw_full <= 1'b0;
      else if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (hs && req_is_store)
        w_full <= 1'b0;
      else if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_valid    <= 1'b0;
      req_is_store <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      info_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (can_grant) begin
            state     <= ST_ISSUE;
            req_valid <= 1'b1;
            if (gnt_wr) begin
              req_is_store <= 1'b1;
              req_addr     <= aw_addr;
              req_wdata    <= w_data;
              req_wstrb    <= w_strb;
              info_q       <= store_info();
            end else if (gnt_rd) begin
              req_is_store <= 1'b0;
              req_addr     <= rd_addr;
              req_wdata    <= '0;
              req_wstrb    <= '0;
              info_q       <= load_info(rd_addr[3]);
            end
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            state     <= ST_IDLE;
            req_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Grants stop at the limit, so a handshake never pushes the count past MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (hs && !rsp_done)
        outstanding <= outstanding + 1'b1;
      else if (!hs && rsp_done && (outstanding != '0))
        outstanding <= outstanding - 1'b1;
      if (rsp_done && (outstanding == '0))
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axilite_req_scheduler.sv
// Directed bench for axilite_req_scheduler: latency, write pairing, round-robin,
// credit limit, counter corner cases and reset while issuing.
module tb_axilite_req_scheduler;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata;
  logic        s_axi_arvalid, s_axi_awvalid, s_axi_wvalid;
  logic        s_axi_arready, s_axi_awready, s_axi_wready;
  logic [7:0]  s_axi_wstrb;
  logic        req_valid, req_ready, req_is_store;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [5:0]  txn_info_wr_data;
  logic        txn_info_wr, rsp_done, err_underflow;
  logic [4:0]  outstanding;

  int n_vec = 0;
  int n_err = 0;

  axilite_req_scheduler #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .txn_info_wr_data(txn_info_wr_data), .txn_info_wr(txn_info_wr),
    .rsp_done(rsp_done), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [63:0] addr);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic load_both(input logic [63:0] raddr, input logic [63:0] waddr,
                           input logic [63:0] wdata);
    s_axi_araddr  = raddr;  s_axi_arvalid = 1'b1;
    s_axi_awaddr  = waddr;  s_axi_awvalid = 1'b1;
    s_axi_wdata   = wdata;  s_axi_wstrb   = 8'hFF; s_axi_wvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  // Waits (bounded) for the next request, checks its type, then lets it handshake.
  task automatic wait_issue(input string tag, input logic exp_store);
    int n = 0;
    while (!req_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(req_valid), 64'd1);
    chk({tag, "_store"}, 64'(req_is_store), 64'(exp_store));
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata  = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
    req_ready = 1'b0; rsp_done = 1'b0;
    step(); step();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_txn_wr", 64'(txn_info_wr), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_arready", 64'(s_axi_arready), 64'd1);
    chk("rst_awready", 64'(s_axi_awready), 64'd1);
    chk("rst_wready", 64'(s_axi_wready), 64'd1);

    // Single read: capture edge, grant edge, handshake edge
    req_ready = 1'b1;
    do_read(64'h1008);
    chk("rd_cap_valid", 64'(req_valid), 64'd0);
    chk("rd_cap_arready", 64'(s_axi_arready), 64'd0);
    chk("rd_cap_txn_wr", 64'(txn_info_wr), 64'd0);
    step();
    chk("rd_valid", 64'(req_valid), 64'd1);
    chk("rd_store", 64'(req_is_store), 64'd0);
    chk("rd_addr", req_addr, 64'h1008);
    chk("rd_txn_wr", 64'(txn_info_wr), 64'd1);
    chk("rd_txn_data", 64'(txn_info_wr_data), 64'b010101);
    step();
    chk("rd_hs_valid", 64'(req_valid), 64'd0);
    chk("rd_outstanding", 64'(outstanding), 64'd1);
    chk("rd_arready_back", 64'(s_axi_arready), 64'd1);
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("rd_retired", 64'(outstanding), 64'd0);

    // Write: AW first, W three cycles later
    s_axi_awaddr = 64'h2000; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    chk("aw_awready", 64'(s_axi_awready), 64'd0);
    step(); step();
    chk("aw_no_issue", 64'(req_valid), 64'd0);
    s_axi_wdata = 64'hDEAD_BEEF; s_axi_wstrb = 8'h0F; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    chk("w_cap_no_issue", 64'(req_valid), 64'd0);
    chk("w_wready", 64'(s_axi_wready), 64'd0);
    step();
    chk("wr_valid", 64'(req_valid), 64'd1);
    chk("wr_store", 64'(req_is_store), 64'd1);
    chk("wr_addr", req_addr, 64'h2000);
    chk("wr_wdata", req_wdata, 64'hDEAD_BEEF);
    chk("wr_wstrb", 64'(req_wstrb), 64'h0F);
    chk("wr_txn_data", 64'(txn_info_wr_data), 64'b100010);
    step();
    chk("wr_outstanding", 64'(outstanding), 64'd1);
    chk("wr_slots_free", 64'({s_axi_awready, s_axi_wready}), 64'b11);
    rsp_done = 1'b1; step(); rsp_done = 1'b0;

    // Round-robin: last grant was write, so first contention goes to read
    load_both(64'h3000, 64'h4000, 64'h11);
    wait_issue("rr1", 1'b0);
    wait_issue("rr2", 1'b1);
    do_read(64'h3008);
    wait_issue("rr3", 1'b0);
    load_both(64'h3010, 64'h4010, 64'h22);
    wait_issue("rr4", 1'b1);
    wait_issue("rr5", 1'b0);
    chk("rr_outstanding", 64'(outstanding), 64'd5);

    // Handshake and retire in the same cycle hold the count
    do_read(64'h10);
    step();
    chk("co_valid", 64'(req_valid), 64'd1);
    rsp_done = 1'b1;
    step();
    rsp_done = 1'b0;
    chk("co_outstanding", 64'(outstanding), 64'd5);
    rsp_done = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("drain_zero", 64'(outstanding), 64'd0);
    chk("drain_no_err", 64'(err_underflow), 64'd0);
    step();
    rsp_done = 1'b0;
    chk("uf_count", 64'(outstanding), 64'd0);
    chk("uf_err", 64'(err_underflow), 64'd1);
    step();
    chk("uf_sticky", 64'(err_underflow), 64'd1);

    // Credit limit: 16 issue, the 17th waits for a retire
    for (int i = 0; i < 16; i++) begin
      do_read(64'(i * 16));
      wait_issue("lim", 1'b0);
    end
    chk("lim_16", 64'(outstanding), 64'd16);
    do_read(64'h500);
    step(); step(); step();
    chk("lim_blocked", 64'(req_valid), 64'd0);
    chk("lim_arready", 64'(s_axi_arready), 64'd0);
    chk("lim_hold", 64'(outstanding), 64'd16);
    rsp_done = 1'b1; step(); rsp_done = 1'b0;
    chk("lim_retire", 64'(outstanding), 64'd15);
    wait_issue("lim17", 1'b0);
    chk("lim_refill", 64'(outstanding), 64'd16);
    chk("lim_arready_back", 64'(s_axi_arready), 64'd1);

    // Reset while a request is pending
    rsp_done = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rsp_done = 1'b0;
    req_ready = 1'b0;
    do_read(64'h40);
    step();
    chk("rst_mid_valid_pre", 64'(req_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    req_ready = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(req_valid), 64'd0);
    chk("rst_mid_txn_wr", 64'(txn_info_wr), 64'd0);
    chk("rst_mid_outstanding", 64'(outstanding), 64'd0);
    chk("rst_mid_err", 64'(err_underflow), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_rel_arready", 64'(s_axi_arready), 64'd1);
    chk("rst_rel_valid", 64'(req_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
